// File: rtl/rr_arbiter_4_amisha.sv
// 4-requester round-robin arbiter driving a 2-to-4 grant decoder (index + valid).
// Optional hold-timeout rotation is enabled by defining RR_ARB_TIMEOUT_EN.
module rr_arbiter_4_amisha #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk_amisha,
  input  logic       rst_n_amisha,
  input  logic [3:0] req_amisha,
  input  logic       arb_en_amisha,
  output logic [1:0] a_amisha,
  output logic       en_amisha,
  output logic       timeout_amisha
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] a_q, a_d;
  logic       en_q, en_d;
  logic [1:0] last_ptr_q, last_ptr_d;
  logic [3:0] others;
  logic       owner_keeps;
  logic       forced;

  if (MAX_HOLD < 2 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_params
    $error("rr_arbiter_4_amisha: need MAX_HOLD >= 2 and 2**CNT_W > MAX_HOLD");
  end

  // First set bit of mask at or after start, wrapping 3 -> 0.
  function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (mask[idx]) rr_pick = idx;
    end
  endfunction

  assign others      = req_amisha & ~(4'b0001 << a_q);
  assign owner_keeps = req_amisha[a_q] && arb_en_amisha;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    a_d        = a_q;
    en_d       = en_q;
    last_ptr_d = last_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (arb_en_amisha && (req_amisha != 4'b0000)) begin
          state_d = GRANT;
          a_d     = rr_pick(req_amisha, last_ptr_q + 2'd1);
          en_d    = 1'b1;
        end
      end
      GRANT: begin
        if (!(owner_keeps && !forced)) begin
          last_ptr_d = a_q;
          if (arb_en_amisha && (others != 4'b0000)) begin
            // Handover without a bubble; the old owner is excluded and so ranks last.
            a_d = rr_pick(others, a_q + 2'd1);
          end else begin
            state_d = IDLE;
            en_d    = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      state_q    <= IDLE;
      a_q        <= 2'd0;
      en_q       <= 1'b0;
      last_ptr_q <= 2'd3;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      en_q       <= en_d;
      last_ptr_q <= last_ptr_d;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_q;
  logic             hold_at_max;
  logic             timeout_q;

  assign hold_at_max = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
  assign forced      = (state_q == GRANT) && owner_keeps && hold_at_max && (others != 4'b0000);

  // Counter clears on any cycle the owner does not keep the grant, so a fresh grant starts at 0.
  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= forced;
      if ((state_q == GRANT) && owner_keeps && !forced) begin
        if (!hold_at_max) hold_cnt_q <= hold_cnt_q + 1'b1;
      end else begin
        hold_cnt_q <= '0;
      end
    end
  end

  assign timeout_amisha = timeout_q;
`else
  assign forced         = 1'b0;
  assign timeout_amisha = 1'b0;
`endif

  assign a_amisha  = a_q;
  assign en_amisha = en_q;

endmodule

// File: tb/tb_rr_arbiter_4_amisha.sv
// Self-checking bench for rr_arbiter_4_amisha: directed scenarios then random traffic,
// compared every cycle against a behavioural round-robin model.
module tb_rr_arbiter_4_amisha;

  localparam int MAX_HOLD = 8;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       arb_en;
  logic [1:0] a;
  logic       en;
  logic       timeout;

  int vectors = 0;
  int errors  = 0;

  // Behavioural model state
  int m_a, m_last, m_hold;
  bit m_en, m_to;

  rr_arbiter_4_amisha #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk_amisha    (clk),
    .rst_n_amisha  (rst_n),
    .req_amisha    (req),
    .arb_en_amisha (arb_en),
    .a_amisha      (a),
    .en_amisha     (en),
    .timeout_amisha(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task model_reset();
    m_a = 0; m_en = 1'b0; m_to = 1'b0; m_last = 3; m_hold = 0;
  endtask

  task model_step();
    logic [3:0] oth;
    bit keeps, force_rot;
    m_to = 1'b0;
    if (!m_en) begin
      if (arb_en && req != 4'b0000) begin
        m_a = pick(req, (m_last + 1) % 4);
        m_en = 1'b1;
        m_hold = 0;
      end
    end else begin
      oth = req & ~(4'b0001 << m_a);
      keeps = req[m_a] && arb_en;
      force_rot = keeps && TO_EN && (m_hold == MAX_HOLD - 1) && (oth != 4'b0000);
      if (keeps && !force_rot) begin
        if (m_hold < MAX_HOLD - 1) m_hold++;
      end else begin
        m_last = m_a;
        if (arb_en && oth != 4'b0000) begin
          m_a = pick(oth, (m_a + 1) % 4);
          m_hold = 0;
          m_to = force_rot;
        end else begin
          m_en = 1'b0;
        end
      end
    end
  endtask

  task check_all(input string tag);
    logic [3:0] y_dut, y_exp;
    y_dut = en ? (4'b0001 << a) : 4'b0000;
    y_exp = m_en ? (4'b0001 << m_a) : 4'b0000;
    check({tag, ".a"}, 32'(a), m_a);
    check({tag, ".en"}, 32'(en), 32'(m_en));
    check({tag, ".timeout"}, 32'(timeout), 32'(m_to));
    check({tag, ".y"}, 32'(y_dut), 32'(y_exp));
  endtask

  task tick(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    // T1: reset with all requests asserted
    rst_n = 1'b0; req = 4'hF; arb_en = 1'b1;
    model_reset();
    #12;
    check_all("t1_reset");
    check("t1_reset_en", 32'(en), 32'd0);
    rst_n = 1'b1;
    tick("t1_first");
    check("t1_first_a", 32'(a), 32'd0);
    check("t1_first_en", 32'(en), 32'd1);

    // T2: rotation with each owner dropping for one cycle
    for (int i = 0; i < 4; i++) begin
      req = 4'hF & ~(4'b0001 << i);
      tick("t2_rot");
      check("t2_rot_a", 32'(a), 32'((i + 1) % 4));
      check("t2_rot_en", 32'(en), 32'd1);
    end
    req = 4'hF;
    tick("t2_hold");

    // T3: sparse wrap and single requester re-grant
    req = 4'b0000; tick("t3_idle");
    req = 4'b0100; tick("t3_g2");
    check("t3_g2_a", 32'(a), 32'd2);
    req = 4'b0011; tick("t3_wrap0");
    check("t3_wrap0_a", 32'(a), 32'd0);
    req = 4'b0010; tick("t3_wrap1");
    check("t3_wrap1_a", 32'(a), 32'd1);
    req = 4'b0100; tick("t3_single");
    req = 4'b0000; tick("t3_single_rel");
    check("t3_single_rel_en", 32'(en), 32'd0);
    check("t3_single_rel_a", 32'(a), 32'd2);
    req = 4'b0100; tick("t3_single_regrant");
    check("t3_single_regrant_en", 32'(en), 32'd1);
    check("t3_single_regrant_a", 32'(a), 32'd2);

    // T4: enable drop, then asynchronous reset mid-grant
    arb_en = 1'b0; tick("t4_disable");
    check("t4_disable_en", 32'(en), 32'd0);
    arb_en = 1'b1; tick("t4_reenable");
    #2 rst_n = 1'b0;
    #1 check("t4_async_en", 32'(en), 32'd0);
    model_reset();
    check_all("t4_async");
    #1 rst_n = 1'b1;
    tick("t4_after_reset");
    check("t4_after_reset_a", 32'(a), 32'd2);

    // T5: long hold by owner 1 with requester 3 waiting
    req = 4'b0010; tick("t5_g1");
    req = 4'b1010;
    for (int i = 0; i < 7; i++) begin
      tick("t5_hold");
      check("t5_hold_a", 32'(a), 32'd1);
    end
    tick("t5_limit");
`ifdef RR_ARB_TIMEOUT_EN
    check("t5_limit_a", 32'(a), 32'd3);
    check("t5_limit_timeout", 32'(timeout), 32'd1);
`else
    check("t5_limit_a", 32'(a), 32'd1);
    check("t5_limit_timeout", 32'(timeout), 32'd0);
`endif
    tick("t5_after");
    check("t5_after_timeout", 32'(timeout), 32'd0);
    req = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      tick("t5_alone");
      check("t5_alone_a", 32'(a), 32'd1);
      check("t5_alone_timeout", 32'(timeout), 32'd0);
    end

    // Random traffic; the owner tends to keep its request so long holds occur
    for (int i = 0; i < 600; i++) begin
      req = 4'($urandom);
      if (m_en && $urandom_range(0, 3) != 0) req[m_a] = 1'b1;
      arb_en = ($urandom_range(0, 15) != 0);
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
